// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and helpers for the shift-add multiplier sequencer.
package mult_ctrl_pkg;

   // Sequencer states; the per-bit work is tracked by a separate iteration counter.
   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StClr   = 3'd1,
      StAdd   = 3'd2,
      StShift = 3'd3,
      StHold  = 3'd4
   } state_t;

   // Iteration counter width; never below one bit so degenerate widths still elaborate.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Handshake and strobe bundle between the multiplier top level and its sequencer.
interface mult_seq_ctrl_if;

   logic ClearA_LoadB;
   logic Run;
   logic M;
   logic Clr_XA;
   logic Ld_B;
   logic Add;
   logic Sub;
   logic Shift_En;
   logic Busy;
   logic Done;

   // Top level / switches side: issues requests and the multiplier bit, observes strobes.
   modport master (
      output ClearA_LoadB, Run, M,
      input  Clr_XA, Ld_B, Add, Sub, Shift_En, Busy, Done
   );

   // Sequencer side.
   modport slave (
      input  ClearA_LoadB, Run, M,
      output Clr_XA, Ld_B, Add, Sub, Shift_En, Busy, Done
   );

endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the N-bit signed shift-add multiplier: fixed FSM plus iteration counter.
// Each Run press performs N-1 conditional adds, one conditional subtract, and N shifts.
module mult_seq_ctrl
   import mult_ctrl_pkg::*;
#(
   parameter int unsigned N          = 8,
   parameter bit          CLR_ON_RUN = 1'b1
) (
   input logic              Clk,
   input logic              Reset,
   mult_seq_ctrl_if.slave   bus
);

   localparam int unsigned     CntW    = cnt_width(N);
   localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

   state_t          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            last_iter;

   // The final iteration handles the sign bit, so it subtracts instead of adding.
   assign last_iter = (cnt_q == LastCnt);

   // State and iteration counter registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and counter update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (bus.Run) begin
               state_d = StClr;
               cnt_d   = '0;
            end
         end
         StClr:   state_d = StAdd;
         StAdd:   state_d = StShift;
         StShift: begin
            if (last_iter) begin
               state_d = StHold;
            end else begin
               cnt_d   = cnt_q + CntW'(1);
               state_d = StAdd;
            end
         end
         // Wait for Run to drop so a held button cannot retrigger.
         StHold: begin
            if (!bus.Run) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Moore outputs; Add/Sub additionally gated by the live multiplier bit.
   always_comb begin
      bus.Clr_XA   = 1'b0;
      bus.Ld_B     = 1'b0;
      bus.Add      = 1'b0;
      bus.Sub      = 1'b0;
      bus.Shift_En = 1'b0;
      bus.Busy     = 1'b0;
      bus.Done     = 1'b0;
      unique case (state_q)
         StIdle: begin
            bus.Clr_XA = bus.ClearA_LoadB;
            bus.Ld_B   = bus.ClearA_LoadB;
         end
         // Always visited so latency is independent of CLR_ON_RUN.
         StClr: begin
            bus.Clr_XA = CLR_ON_RUN;
            bus.Busy   = 1'b1;
         end
         StAdd: begin
            bus.Busy = 1'b1;
            bus.Add  = bus.M & ~last_iter;
            bus.Sub  = bus.M & last_iter;
         end
         StShift: begin
            bus.Shift_En = 1'b1;
            bus.Busy     = 1'b1;
         end
         StHold: bus.Done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: one instance per CLR_ON_RUN setting, shared stimulus.
module tb_mult_seq_ctrl;

   localparam int N = 8;

   typedef struct {
      int adds;
      int subs;
      int both;
      int shifts;
      int sh0;
      int lat;
      int busy;
      int sub_iter;
      int clr1;
      int ld1;
      int clr0;
   } res_t;

   logic Clk;
   logic Reset;

   int   n_assert;
   int   n_fail;
   res_t exp_q[$];

   mult_seq_ctrl_if bus1 ();
   mult_seq_ctrl_if bus0 ();

   mult_seq_ctrl #(.N(N), .CLR_ON_RUN(1'b1)) dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1));
   mult_seq_ctrl #(.N(N), .CLR_ON_RUN(1'b0)) dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic clrld, input logic run, input logic m);
      bus1.ClearA_LoadB = clrld;
      bus1.Run          = run;
      bus1.M            = m;
      bus0.ClearA_LoadB = clrld;
      bus0.Run          = run;
      bus0.M            = m;
   endtask

   // Expected outcome of one full operation, computed from the multiplier bit.
   function automatic res_t model(input logic m);
      res_t r;
      r.adds     = m ? N - 1 : 0;
      r.subs     = m ? 1 : 0;
      r.both     = 0;
      r.shifts   = N;
      r.sh0      = N;
      r.lat      = 2 * N + 2;
      r.busy     = 2 * N + 1;
      r.sub_iter = m ? N - 1 : -1;
      r.clr1     = 1;
      r.ld1      = 0;
      r.clr0     = 0;
      return r;
   endfunction

   // Start one operation and collect strobe activity until Done; leaves Run high.
   task automatic do_op(input string tag, input logic m, input logic clrld);
      res_t got, exp;
      got = '{default: 0};
      got.sub_iter = -1;
      got.lat      = -1;
      @(negedge Clk);
      set_in(clrld, 1'b1, m);
      #1;
      check({tag, ".idle_clr0"}, 32'(bus0.Clr_XA), 32'(clrld));
      exp_q.push_back(model(m));
      for (int k = 1; k <= 100; k++) begin
         @(negedge Clk);
         if (bus1.Add) got.adds++;
         if (bus1.Sub) begin
            got.subs++;
            got.sub_iter = got.shifts;
         end
         if (bus1.Add && bus1.Sub) got.both++;
         if (bus1.Shift_En) got.shifts++;
         if (bus0.Shift_En) got.sh0++;
         if (bus1.Busy) got.busy++;
         if (bus1.Clr_XA) got.clr1++;
         if (bus1.Ld_B) got.ld1++;
         if (bus0.Clr_XA || bus0.Ld_B) got.clr0++;
         if (bus1.Done) begin
            got.lat = k;
            break;
         end
      end
      exp = exp_q.pop_front();
      check({tag, ".latency"},  32'(got.lat),      32'(exp.lat));
      check({tag, ".adds"},     32'(got.adds),     32'(exp.adds));
      check({tag, ".subs"},     32'(got.subs),     32'(exp.subs));
      check({tag, ".add_sub"},  32'(got.both),     32'(exp.both));
      check({tag, ".shifts"},   32'(got.shifts),   32'(exp.shifts));
      check({tag, ".shifts0"},  32'(got.sh0),      32'(exp.sh0));
      check({tag, ".busy"},     32'(got.busy),     32'(exp.busy));
      check({tag, ".sub_iter"}, 32'(got.sub_iter), 32'(exp.sub_iter));
      check({tag, ".clr1"},     32'(got.clr1),     32'(exp.clr1));
      check({tag, ".ld1"},      32'(got.ld1),      32'(exp.ld1));
      check({tag, ".clr0"},     32'(got.clr0),     32'(exp.clr0));
   endtask

   // Drop Run from HOLD; the FSM must be back in IDLE one edge later.
   task automatic release_run(input string tag, input logic clrld);
      @(negedge Clk);
      set_in(clrld, 1'b0, 1'b0);
      #1;
      check({tag, ".done_before_edge"}, 32'(bus1.Done), 32'd1);
      @(negedge Clk);
      check({tag, ".done_cleared"}, 32'(bus1.Done), 32'd0);
      check({tag, ".busy_idle"},    32'(bus1.Busy), 32'd0);
      check({tag, ".idle_clr0"},    32'(bus0.Clr_XA), 32'(clrld));
   endtask

   initial begin
      int bad_done;
      int extra;
      int shifts;
      bit hit;
      n_assert = 0;
      n_fail   = 0;

      // Reset asserted: IDLE outputs follow ClearA_LoadB with no clock needed.
      Reset = 1'b0;
      set_in(1'b1, 1'b0, 1'b0);
      #3;
      check("rst.clr_xa",  32'(bus1.Clr_XA),   32'd1);
      check("rst.ld_b",    32'(bus1.Ld_B),     32'd1);
      check("rst.busy",    32'(bus1.Busy),     32'd0);
      check("rst.done",    32'(bus1.Done),     32'd0);
      check("rst.shift",   32'(bus1.Shift_En), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      check("idle.clr_xa", 32'(bus1.Clr_XA),   32'd1);
      check("idle.ld_b",   32'(bus0.Ld_B),     32'd1);
      check("idle.busy",   32'(bus1.Busy),     32'd0);
      check("idle.shift",  32'(bus1.Shift_En), 32'd0);
      set_in(1'b0, 1'b0, 1'b0);

      // M=1 held, then M=0 held.
      do_op("m1", 1'b1, 1'b0);
      release_run("m1", 1'b0);
      do_op("m0", 1'b0, 1'b0);
      release_run("m0", 1'b0);

      // Run held long after Done: no retrigger, Done stays high.
      do_op("hold", 1'b1, 1'b0);
      bad_done = 0;
      extra    = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge Clk);
         if (!bus1.Done) bad_done++;
         if (bus1.Shift_En || bus1.Busy) extra++;
      end
      check("hold.done_low_cycles", 32'(bad_done), 32'd0);
      check("hold.extra_activity",  32'(extra),    32'd0);
      release_run("hold", 1'b0);

      // Reset pulsed during the SHIFT of iteration 3.
      @(negedge Clk);
      set_in(1'b0, 1'b1, 1'b1);
      shifts = 0;
      hit    = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge Clk);
         if (bus1.Shift_En) begin
            if (shifts == 3) begin
               hit = 1'b1;
               break;
            end
            shifts++;
         end
      end
      check("rstmid.reached_iter3", 32'(hit), 32'd1);
      Reset = 1'b0;
      set_in(1'b0, 1'b0, 1'b1);
      #1;
      check("rstmid.shift", 32'(bus1.Shift_En), 32'd0);
      check("rstmid.busy",  32'(bus1.Busy),     32'd0);
      check("rstmid.done",  32'(bus1.Done),     32'd0);
      check("rstmid.add",   32'(bus1.Add),      32'd0);
      check("rstmid.clr",   32'(bus1.Clr_XA),   32'd0);
      #2;
      Reset = 1'b1;
      @(negedge Clk);
      check("rstmid.idle_busy", 32'(bus1.Busy), 32'd0);
      do_op("after_rst", 1'b1, 1'b0);
      release_run("after_rst", 1'b0);

      // ClearA_LoadB held throughout: only honoured while IDLE.
      do_op("clrld", 1'b1, 1'b1);
      release_run("clrld", 1'b1);
      set_in(1'b0, 1'b0, 1'b0);

      check("scoreboard.empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Counter-based sequencer for the N-bit shift-add signed multiplier datapath (X/A/B registers, adder/subtractor).
- Replaces the hand-enumerated per-bit state list with a fixed FSM plus an iteration counter.
- Issues load, clear, add, subtract and shift strobes: N-1 conditional adds, one conditional subtract on the sign bit, then N shifts.
- Runs exactly one multiply per Run press. Reports Busy/Done to the top level.

Parameters:
- N, 8, multiplier width; number of add/shift iterations.
- CLR_ON_RUN, 1, 1 = clear X and A at start of each run; 0 = keep A so runs can be chained.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- ClearA_LoadB  in  1  level; in IDLE, clear X/A and load B
- Run  in  1  level, already synchronised and debounced; start request
- M  in  1  current LSB of B (multiplier bit under test)
- Clr_XA  out  1  clear X and A registers
- Ld_B  out  1  load B from switches
- Add  out  1  add S to A this cycle
- Sub  out  1  subtract S from A this cycle
- Shift_En  out  1  arithmetic right shift of X:A:B
- Busy  out  1  operation in progress
- Done  out  1  operation complete, held until Run released

Behaviour:
- States: IDLE, CLR, ADD, SHIFT, HOLD. State register and counter cnt ($clog2(N) bits) are asynchronously reset to IDLE and 0 when Reset=0.
- Outputs are Moore-decoded from state, except Add/Sub, which are also gated by M in the same cycle (combinational).
- IDLE:
  - Clr_XA = Ld_B = ClearA_LoadB; all other outputs 0.
  - Run=1 -> CLR, cnt <= 0.
  - If ClearA_LoadB and Run are both 1, the load is honoured this cycle and the run starts next cycle.
- CLR (1 cycle):
  - Clr_XA = CLR_ON_RUN; Busy=1.
  - Goes to ADD. The state is always visited, so latency does not depend on CLR_ON_RUN.
- ADD (1 cycle):
  - Busy=1.
  - If cnt < N-1: Add = M, Sub = 0.
  - If cnt == N-1: Sub = M, Add = 0.
  - Add and Sub are never both 1.
  - Goes to SHIFT.
- SHIFT (1 cycle):
  - Shift_En=1, Busy=1.
  - If cnt == N-1 -> HOLD; else cnt <= cnt+1 -> ADD.
- HOLD:
  - Done=1, Busy=0, all strobes 0.
  - Run=0 -> IDLE; Run still 1 -> remain in HOLD (no retrigger).
- Latency: Run sampled high in IDLE at edge 0 -> CLR in cycle 1 -> ADD/SHIFT cycles 2..2N+1 -> Done high from cycle 2N+2 (cycle 18 for N=8).
- Exactly N Shift_En pulses per operation; at most N-1 Add and at most 1 Sub pulse.
- ClearA_LoadB is ignored in every state except IDLE.
- M changes between ADD cycles are expected (B shifts); only its value during an ADD cycle matters.
- Reset mid-operation:
  - Immediate return to IDLE, cnt=0.
  - Busy, Done, Add, Sub and Shift_En drop asynchronously. Clr_XA/Ld_B follow ClearA_LoadB as in IDLE.
  - The interrupted operation is lost. The next Run starts a full N-iteration sequence.
- Run dropping during CLR/ADD/SHIFT does not abort; the FSM goes to HOLD then IDLE on the first cycle Run=0.

Decomposition:
- Package mult_ctrl_pkg holds the state enum typedef (3-bit logic), and a localparam function for counter width.
- No sub-module is needed. The iteration counter stays inline, as it is a few lines.

Test Plan:
- Reset low then high; ClearA_LoadB=1, Run=0 -> Clr_XA=Ld_B=1 same cycle, Busy=Done=0, no Shift_En.
- N=8, M=1 held, one Run press -> Add pulses in iterations 0..6 (7 total), Sub=1 only in iteration 7, 8 Shift_En pulses, Done=1 at cycle 18.
- M=0 held, Run -> Add=Sub=0 throughout, exactly 8 Shift_En pulses, Done at cycle 18.
- Run held high 50 cycles -> exactly one operation (8 shifts); Done stays 1 until Run=0, then IDLE next cycle with Done=0.
- Reset pulsed low during SHIFT of iteration 3 -> outputs clear without waiting for Clk; next Run yields full 8 shifts and Done at cycle 18.
- ClearA_LoadB=1 throughout an operation, CLR_ON_RUN=0 -> Clr_XA/Ld_B stay 0 from CLR through HOLD; Clr_XA=1 only in IDLE.
